// File: rtl/note_lut.sv
// note_lut -- registered-output ROM mapping a MIDI note number to the
// 16-bit oscillator frequency divider round(500000 / f(n)), where
// f(n) = 440 * 2^((n-69)/12) Hz. The contents are fixed constants, so the
// table maps onto block RAM or LUT ROM.
//
// Ports:
//   bram_clk   in   clock; the parent drives the inverted system clock
//   bram_rst   in   synchronous active-high reset, clears the output word
//   bram_ce    in   read enable; high loads a new word, low holds
//   bram_addr  in   note number; addresses with any bit above bit 6 set
//                   are out of range and read as 0 ("voice off")
//   bram_out   out  registered divider word, zero-extended to D_W
//
// Read latency is one clock. The parent loads the address on a system-clock
// rising edge and this ROM samples it on the following falling edge, so the
// address-to-register path only has half a system period of setup.

module note_lut #(
  parameter int ADDR_W = 8,
  parameter int D_W    = 16
) (
  input  logic              bram_clk,
  input  logic              bram_rst,
  input  logic              bram_ce,
  input  logic [ADDR_W-1:0] bram_addr,
  output logic [D_W-1:0]    bram_out
);

  logic [15:0]    rom_word;
  logic [D_W-1:0] rom_data;
  logic           in_range;
  // Declaration initialiser gives the power-up value of 0 on FPGA targets.
  logic [D_W-1:0] out_q = '0;

  assign in_range = ((bram_addr >> 7) == '0);

  always_comb begin
    rom_word = 16'd0;
    case (bram_addr[6:0])
      7'd0:   rom_word = 16'd61156;
      7'd1:   rom_word = 16'd57724;
      7'd2:   rom_word = 16'd54484;
      7'd3:   rom_word = 16'd51426;
      7'd4:   rom_word = 16'd48540;
      7'd5:   rom_word = 16'd45815;
      7'd6:   rom_word = 16'd43244;
      7'd7:   rom_word = 16'd40817;
      7'd8:   rom_word = 16'd38526;
      7'd9:   rom_word = 16'd36364;
      7'd10:  rom_word = 16'd34323;
      7'd11:  rom_word = 16'd32396;
      7'd12:  rom_word = 16'd30578;
      7'd13:  rom_word = 16'd28862;
      7'd14:  rom_word = 16'd27242;
      7'd15:  rom_word = 16'd25713;
      7'd16:  rom_word = 16'd24270;
      7'd17:  rom_word = 16'd22908;
      7'd18:  rom_word = 16'd21622;
      7'd19:  rom_word = 16'd20408;
      7'd20:  rom_word = 16'd19263;
      7'd21:  rom_word = 16'd18182;
      7'd22:  rom_word = 16'd17161;
      7'd23:  rom_word = 16'd16198;
      7'd24:  rom_word = 16'd15289;
      7'd25:  rom_word = 16'd14431;
      7'd26:  rom_word = 16'd13621;
      7'd27:  rom_word = 16'd12856;
      7'd28:  rom_word = 16'd12135;
      7'd29:  rom_word = 16'd11454;
      7'd30:  rom_word = 16'd10811;
      7'd31:  rom_word = 16'd10204;
      7'd32:  rom_word = 16'd9631;
      7'd33:  rom_word = 16'd9091;
      7'd34:  rom_word = 16'd8581;
      7'd35:  rom_word = 16'd8099;
      7'd36:  rom_word = 16'd7645;
      7'd37:  rom_word = 16'd7215;
      7'd38:  rom_word = 16'd6810;
      7'd39:  rom_word = 16'd6428;
      7'd40:  rom_word = 16'd6067;
      7'd41:  rom_word = 16'd5727;
      7'd42:  rom_word = 16'd5405;
      7'd43:  rom_word = 16'd5102;
      7'd44:  rom_word = 16'd4816;
      7'd45:  rom_word = 16'd4545;
      7'd46:  rom_word = 16'd4290;
      7'd47:  rom_word = 16'd4050;
      7'd48:  rom_word = 16'd3822;
      7'd49:  rom_word = 16'd3608;
      7'd50:  rom_word = 16'd3405;
      7'd51:  rom_word = 16'd3214;
      7'd52:  rom_word = 16'd3034;
      7'd53:  rom_word = 16'd2863;
      7'd54:  rom_word = 16'd2703;
      7'd55:  rom_word = 16'd2551;
      7'd56:  rom_word = 16'd2408;
      7'd57:  rom_word = 16'd2273;
      7'd58:  rom_word = 16'd2145;
      7'd59:  rom_word = 16'd2025;
      7'd60:  rom_word = 16'd1911;
      7'd61:  rom_word = 16'd1804;
      7'd62:  rom_word = 16'd1703;
      7'd63:  rom_word = 16'd1607;
      7'd64:  rom_word = 16'd1517;
      7'd65:  rom_word = 16'd1432;
      7'd66:  rom_word = 16'd1351;
      7'd67:  rom_word = 16'd1276;
      7'd68:  rom_word = 16'd1204;
      7'd69:  rom_word = 16'd1136;
      7'd70:  rom_word = 16'd1073;
      7'd71:  rom_word = 16'd1012;
      7'd72:  rom_word = 16'd956;
      7'd73:  rom_word = 16'd902;
      7'd74:  rom_word = 16'd851;
      7'd75:  rom_word = 16'd804;
      7'd76:  rom_word = 16'd758;
      7'd77:  rom_word = 16'd716;
      7'd78:  rom_word = 16'd676;
      7'd79:  rom_word = 16'd638;
      7'd80:  rom_word = 16'd602;
      7'd81:  rom_word = 16'd568;
      7'd82:  rom_word = 16'd536;
      7'd83:  rom_word = 16'd506;
      7'd84:  rom_word = 16'd478;
      7'd85:  rom_word = 16'd451;
      7'd86:  rom_word = 16'd426;
      7'd87:  rom_word = 16'd402;
      7'd88:  rom_word = 16'd379;
      7'd89:  rom_word = 16'd358;
      7'd90:  rom_word = 16'd338;
      7'd91:  rom_word = 16'd319;
      7'd92:  rom_word = 16'd301;
      7'd93:  rom_word = 16'd284;
      7'd94:  rom_word = 16'd268;
      7'd95:  rom_word = 16'd253;
      7'd96:  rom_word = 16'd239;
      7'd97:  rom_word = 16'd225;
      7'd98:  rom_word = 16'd213;
      7'd99:  rom_word = 16'd201;
      7'd100: rom_word = 16'd190;
      7'd101: rom_word = 16'd179;
      7'd102: rom_word = 16'd169;
      7'd103: rom_word = 16'd159;
      7'd104: rom_word = 16'd150;
      7'd105: rom_word = 16'd142;
      7'd106: rom_word = 16'd134;
      7'd107: rom_word = 16'd127;
      7'd108: rom_word = 16'd119;
      7'd109: rom_word = 16'd113;
      7'd110: rom_word = 16'd106;
      7'd111: rom_word = 16'd100;
      7'd112: rom_word = 16'd95;
      7'd113: rom_word = 16'd89;
      7'd114: rom_word = 16'd84;
      7'd115: rom_word = 16'd80;
      7'd116: rom_word = 16'd75;
      7'd117: rom_word = 16'd71;
      7'd118: rom_word = 16'd67;
      7'd119: rom_word = 16'd63;
      7'd120: rom_word = 16'd60;
      7'd121: rom_word = 16'd56;
      7'd122: rom_word = 16'd53;
      7'd123: rom_word = 16'd50;
      7'd124: rom_word = 16'd47;
      7'd125: rom_word = 16'd45;
      7'd126: rom_word = 16'd42;
      7'd127: rom_word = 16'd40;
      default: rom_word = 16'd0;
    endcase
  end

  // Zero-extend to D_W; the out-of-range region reads as 0.
  always_comb begin
    rom_data = '0;
    if (in_range) begin
      rom_data[15:0] = rom_word;
    end
  end

  always_ff @(posedge bram_clk) begin
    if (bram_rst) begin
      out_q <= '0;
    end else if (bram_ce) begin
      out_q <= rom_data;
    end
  end

  assign bram_out = out_q;

endmodule

// File: tb/tb_note_lut.sv
module tb_note_lut;

  localparam int ADDR_W = 8;
  localparam int D_W    = 16;

  logic              bram_clk;
  logic              bram_rst;
  logic              bram_ce;
  logic [ADDR_W-1:0] bram_addr;
  logic [D_W-1:0]    bram_out;

  int checks;
  int failures;

  // Scoreboard: one entry per driven edge.
  logic [D_W-1:0] exp_q[$];
  bit             chk_q[$];
  string          name_q[$];
  int             idx_q[$];

  logic [D_W-1:0] obs[128];
  logic [D_W-1:0] model_q;

  note_lut #(.ADDR_W(ADDR_W), .D_W(D_W)) dut (
    .bram_clk (bram_clk),
    .bram_rst (bram_rst),
    .bram_ce  (bram_ce),
    .bram_addr(bram_addr),
    .bram_out (bram_out)
  );

  initial begin
    bram_clk = 1'b0;
    forever #5 bram_clk = ~bram_clk;
  end

  function automatic int golden(int n);
    real f;
    real r;
    if (n >= 128) return 0;
    f = 440.0 * $pow(2.0, (n - 69) / 12.0);
    r = 500000.0 / f;
    return int'($floor(r + 0.5));
  endfunction

  // Drive one edge worth of inputs. hand >= 0 supplies a hand-computed
  // expectation; hand < 0 uses the formula-based model. idx >= 0 records
  // the resulting output for the sweep property checks.
  task automatic step(input int addr, input bit ce, input bit rst,
                      input int hand, input string name, input int idx);
    logic [D_W-1:0] e;
    @(negedge bram_clk);
    bram_addr = addr[ADDR_W-1:0];
    bram_ce   = ce;
    bram_rst  = rst;
    if (rst) e = '0;
    else if (ce) e = D_W'(golden(addr));
    else e = model_q;
    if (hand >= 0) e = D_W'(hand);
    model_q = e;
    exp_q.push_back(e);
    chk_q.push_back(1'b1);
    name_q.push_back(name);
    idx_q.push_back(idx);
  endtask

  // Monitor: the output register updates once per rising edge.
  initial begin
    logic [D_W-1:0] e;
    bit c;
    string nm;
    int ix;
    forever begin
      @(posedge bram_clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        c  = chk_q.pop_front();
        nm = name_q.pop_front();
        ix = idx_q.pop_front();
        if (ix >= 0 && ix < 128) obs[ix] = bram_out;
        if (c) begin
          checks++;
          if (bram_out !== e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, bram_out, e);
          end
        end
      end
    end
  end

  initial begin
    int anchor_a[6] = '{0, 57, 60, 69, 81, 127};
    int anchor_v[6] = '{61156, 2273, 1911, 1136, 568, 40};
    int oor[3] = '{128, 200, 255};
    int guard;

    checks   = 0;
    failures = 0;
    model_q  = '0;
    bram_rst  = 1'b0;
    bram_ce   = 1'b0;
    bram_addr = '0;

    #1;
    checks++;
    if (bram_out !== '0) begin
      failures++;
      $display("FAIL powerup: got %0d expected 0", bram_out);
    end

    // Reset held for two edges with a valid read pending.
    step(69, 1'b1, 1'b1, 0, "reset_edge1", -1);
    step(69, 1'b1, 1'b1, 0, "reset_edge2", -1);
    step(69, 1'b1, 1'b0, 1136, "reset_release", -1);

    for (int i = 0; i < 6; i++)
      step(anchor_a[i], 1'b1, 1'b0, anchor_v[i], $sformatf("anchor_%0d", anchor_a[i]), -1);

    for (int n = 0; n < 128; n++)
      step(n, 1'b1, 1'b0, -1, $sformatf("sweep_%0d", n), n);

    for (int i = 0; i < 3; i++)
      step(oor[i], 1'b1, 1'b0, 0, $sformatf("oor_%0d", oor[i]), -1);

    step(60, 1'b1, 1'b0, 1911, "hold_load", -1);
    for (int i = 0; i < 3; i++)
      step(69, 1'b0, 1'b0, 1911, $sformatf("hold_%0d", i), -1);
    step(69, 1'b1, 1'b0, 1136, "hold_resume", -1);

    step(69, 1'b1, 1'b0, 1136, "pipe_69", -1);
    step(81, 1'b1, 1'b0, 568, "pipe_81", -1);
    step(57, 1'b1, 1'b0, 2273, "pipe_57", -1);

    // Reset wins over a simultaneous read, from a nonzero output.
    step(100, 1'b1, 1'b1, 0, "rst_vs_ce", -1);
    step(100, 1'b1, 1'b0, 190, "rst_vs_ce_release", -1);
    step(0, 1'b0, 1'b0, 190, "final_hold", -1);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge bram_clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    for (int n = 0; n < 128; n++) begin
      checks++;
      if (obs[n] === '0 || $isunknown(obs[n])) begin
        failures++;
        $display("FAIL nonzero_%0d: got %0d expected nonzero", n, obs[n]);
      end
      if (n < 127) begin
        checks++;
        if (!(obs[n] >= obs[n+1])) begin
          failures++;
          $display("FAIL monotonic_%0d: got %0d then %0d expected non-increasing",
                   n, obs[n], obs[n+1]);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_lut.md
# note_lut

Synchronous read-only lookup table that converts a MIDI note number into the 16-bit frequency divider consumed by the voice oscillators. It sits inside the MIDI control unit: the parsed note byte drives the address, and the registered divider is latched into the selected voice on Note On. It is implemented as a registered-output ROM, so it maps onto iCE40 block RAM or LUT ROM.

## Interface
- `ADDR_W`, default 8: address width. Only the low 7 bits are meaningful note numbers; bit 7 selects the out-of-range region.
- `D_W`, default 16: data width. Must be ≥ 16; values are zero-extended when wider.
- `bram_clk`, in, 1: clock. One clock; all state updates on its rising edge. The parent drives it with the inverted system clock.
- `bram_rst`, in, 1: reset. Synchronous and active-high.
- `bram_ce`, in, 1: read enable. High = output register loads a new word.
- `bram_addr`, in, `ADDR_W`: MIDI note number.
- `bram_out`, out, `D_W`: registered divider word.

## Operation
- Table contents for note n in 0..127: `round(F_REF / f(n))`.
  - `f(n) = 440 × 2^((n−69)/12)` Hz.
  - `F_REF = 500000` Hz.
  - Rounding is to the nearest integer, with .5 rounded up.
  - Values are precomputed constants in a 128-entry case/ROM; there is no runtime arithmetic.
- Anchor values: n=0 → 61156; n=57 → 2273; n=60 → 1911; n=69 → 1136; n=81 → 568; n=127 → 40.
- Every entry is nonzero, fits in 16 bits, and is monotonically non-increasing with n.
- Addresses 128..255 (bit 7 set) return 0x0000. The controller treats 0 as "voice off".
- Note 0 returns its table value (61156). Muting on note 0 is the controller's responsibility, not this block's.
- Output register update each rising edge, in priority order:
  1. If `bram_rst` = 1: `bram_out` ← 0.
  2. Else if `bram_ce` = 1: `bram_out` ← table[`bram_addr`].
  3. Else: `bram_out` holds.
- No other state; no write port.

## Timing
- Power-up value of `bram_out`: 0 (initialised register).
- Reset value of `bram_out`: 0, applied on the first rising edge with `bram_rst` high. Reset is synchronous only; asserting it between edges has no effect until the next edge.
- Read latency: exactly 1 clock.
  - The address presented before edge k appears on `bram_out` after edge k.
  - The output is stable for the full following cycle.
- Back-to-back addresses are fully pipelined: one new result per clock, no bubbles.
- `bram_ce` low for any number of cycles freezes the output. Address changes during that time are ignored.
- Reset asserted together with `bram_ce` and a valid address: reset wins, output is 0. The first read after release returns data one edge after the release edge.
- Parent usage: the address is loaded on a system-clock rising edge, and the ROM samples it on the next falling edge. Data is therefore valid before the next system-clock rising edge. The ROM must meet a half-period setup for that path.

## Test plan
- Reset: drive `bram_addr`=69, `bram_ce`=1, `bram_rst`=1 for 2 edges → `bram_out`=0. Release reset → 1136 after the next edge.
- Anchor sweep with `ce`=1: addresses 0, 57, 60, 69, 81, 127 → 61156, 2273, 1911, 1136, 568, 40, each appearing one edge after its address.
- Full sweep 0..127: every entry is nonzero and ≤ 65535, and `out[n]` ≥ `out[n+1]` for all n. Each entry matches the golden formula within ±0 after rounding.
- Out of range: addresses 128, 200, 255 → 0x0000.
- Enable hold:
  - Read 60 → 1911.
  - Drop `ce`, change the address to 69 for 3 edges → output stays 1911.
  - Raise `ce` → 1136 after one edge.
- Pipelining: addresses 69, 81, 57 on consecutive edges → outputs 1136, 568, 2273 on the following consecutive edges, each lagging its address by one clock.
